// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Number of beats needed to emit one word.
  function automatic int piso_beats(input int data_width, input int lanes);
    if (lanes < 1) return 1;
    return data_width / lanes;
  endfunction

  // Beat counter width: clog2(beats), never narrower than one bit.
  function automatic int piso_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word input and serial-beat output handshakes of the serializer.
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1
) ();
  import piso_pkg::*;

  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [LANES-1:0]      dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;

  // Producer of words / consumer of beats.
  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );

  // The serializer itself.
  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: LANES bits per beat, LSB- or MSB-lane first,
// valid/ready on both sides, zero-bubble reload on the last beat.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic               clk,
  input  logic               resetn,
  piso_serializer_if.slave   bus,
  output logic               busy
);

  localparam int BEATS = piso_beats(DATA_WIDTH, LANES);
  localparam int CNT_W = piso_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam bit MSB = (MSB_FIRST != 0);

  if ((LANES < 1) || (LANES > DATA_WIDTH) || ((DATA_WIDTH % LANES) != 0)) begin : g_bad_cfg
    $error("piso_serializer: DATA_WIDTH must be a non-zero multiple of LANES and LANES <= DATA_WIDTH");
  end

  piso_state_t           r_state;
  piso_state_t           w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [LANES-1:0]      w_lane;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_consume;
  logic                  w_din_ready;
  logic                  w_accept;

  // Handshake decode; outputs are gated by resetn so they read zero during reset.
  always_comb begin
    w_valid     = resetn && (r_state == SHIFT);
    w_lane      = MSB ? r_shift[DATA_WIDTH-1 -: LANES] : r_shift[LANES-1:0];
    w_shifted   = MSB ? (r_shift << LANES) : (r_shift >> LANES);
    w_last      = w_valid && (r_cnt == LAST_CNT);
    w_consume   = w_valid && bus.dout_ready;
    w_din_ready = resetn && ((r_state == IDLE) || (w_consume && w_last));
    w_accept    = bus.din_valid && w_din_ready;
  end

  // Next state: load wins over shift so a word offered on the last beat follows without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = bus.din;
      w_cnt_nxt   = '0;
    end else if (w_consume) begin
      w_shift_nxt = w_shifted;
      if (w_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

  // State, shift register and beat counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.din_ready  = w_din_ready;
  assign bus.dout       = w_valid ? w_lane : '0;
  assign bus.dout_valid = w_valid;
  assign bus.dout_last  = w_last;
  assign busy           = w_valid;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the parallel input word.
REQ-002 Parameter LANES, default 1: serial bits output per beat; DATA_WIDTH SHALL be an integer multiple of LANES.
REQ-003 Parameter MSB_FIRST, default 0: 0 = LSB lane shifted out first, 1 = MSB lane shifted out first.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 din  input  DATA_WIDTH  parallel word to serialise.
REQ-007 din_valid  input  1  din holds a valid word.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 dout  output  LANES  current serial beat.
REQ-010 dout_valid  output  1  dout holds a valid beat.
REQ-011 dout_ready  input  1  downstream consumes the beat this cycle.
REQ-012 dout_last  output  1  marks the final beat of a word.
REQ-013 busy  output  1  a word is in flight (state SHIFT).

Function
REQ-014 BEATS = DATA_WIDTH/LANES; the beat counter SHALL be clog2(BEATS) bits wide, minimum 1 bit.
REQ-015 States: IDLE (no word held) and SHIFT (word held, beats pending).
REQ-016 Word acceptance: a word is accepted when din_valid and din_ready are both high on a clock edge.
REQ-017 din_ready SHALL equal resetn AND (state==IDLE OR (dout_valid AND dout_ready AND dout_last)).
REQ-018 On acceptance: din is loaded into the shift register, beat counter = 0, state = SHIFT, dout_valid = 1 in the next cycle (latency 1 cycle from acceptance to first beat).
REQ-019 Lane mapping, MSB_FIRST=0: dout = shift register [LANES-1:0]; on each consumed beat, the register shifts right by LANES with zero fill.
REQ-020 Lane mapping, MSB_FIRST=1: dout = shift register [DATA_WIDTH-1 -: LANES]; on each consumed beat, the register shifts left by LANES with zero fill.
REQ-021 A beat is consumed when dout_valid and dout_ready are both high; only then do the register and counter advance.
REQ-022 With dout_ready low, dout, dout_valid and dout_last SHALL hold their values (no beat lost or repeated).
REQ-023 dout_last SHALL be high exactly when dout_valid is high and beat counter == BEATS-1; with BEATS=1 it is high on every beat.
REQ-024 Last beat consumed with din_valid high: the new word loads in the same edge and SHIFT continues with zero bubble cycles.
REQ-025 Last beat consumed with din_valid low: state = IDLE, dout_valid = 0.
REQ-026 In IDLE: dout = 0, dout_valid = 0, dout_last = 0.
REQ-027 din_valid in SHIFT before the last beat is ignored; din SHALL NOT be sampled.

Reset
REQ-028 With resetn low at a clock edge: state = IDLE, shift register = 0, beat counter = 0.
REQ-029 Output values during reset: dout = 0, dout_valid = 0, dout_last = 0, busy = 0, din_ready = 0.
REQ-030 Reset mid-word SHALL discard the word; no further beats of that word appear after resetn returns high.
REQ-031 The first word after reset SHALL be accepted in the first cycle with resetn high.

Structure
REQ-032 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and a constant function computing BEATS and the counter width.
REQ-033 An elaboration-time check SHALL reject DATA_WIDTH % LANES != 0 and LANES > DATA_WIDTH.
REQ-034 No sub-module; single module with one register process and combinational next-state/output logic.

Verification
REQ-035 Scenario LSB-first: DATA_WIDTH=16, LANES=1, MSB_FIRST=0, din=16'hA5C3, dout_ready=1 -> dout sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; dout_last on beat 16 only.
REQ-036 Scenario MSB-first nibbles: LANES=4, MSB_FIRST=1, din=16'h1234 -> dout 4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles; dout_last with 4'h4.
REQ-037 Scenario backpressure: LANES=4, din=16'hBEEF, LSB-first, dout_ready low for 3 cycles after beat 2 -> dout holds 4'hE during the stall; sequence F,E,E,B with no loss or duplication.
REQ-038 Scenario back-to-back: LANES=4, words 16'h1111 and 16'h2222 offered continuously -> 8 contiguous valid beats; din_ready high only in the initial IDLE cycle and the last-beat cycle.
REQ-039 Scenario reset mid-word: resetn low after beat 2 of 16'hA5C3 -> dout_valid=0 next cycle; next word 16'h0001 serialises cleanly with no residue from 16'hA5C3.
REQ-040 A bench assertion SHALL check dout against a reference model of the accepted word and beat index on every consumed beat.
